// File: rtl/uart_frame_pkg.sv
// Shared framing constants and parser state encoding for the UART register-write link.
package uart_frame_pkg;

    localparam logic [7:0] SOF = 8'hA5;
    localparam logic [7:0] ACK = 8'h06;
    localparam logic [7:0] NAK = 8'h15;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        LEN,
        PAYLOAD,
        CHK,
        COMMIT,
        RESP
    } state_e;

endpackage

// File: rtl/frame_timeout.sv
// Inter-byte idle counter: counts enabled cycles and flags expiry once TIMEOUT is reached.
module frame_timeout #(
    parameter int TIMEOUT = 50000,
    parameter int TO_W    = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear_i,
    input  logic en_i,
    output logic expire_o
);

    logic [TO_W-1:0] cnt_q;

    // Counter parks at TIMEOUT so expiry stays asserted until the parser clears it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (clear_i) begin
            cnt_q <= '0;
        end else if (en_i && !expire_o) begin
            cnt_q <= cnt_q + TO_W'(1);
        end
    end

    assign expire_o = (cnt_q >= TO_W'(TIMEOUT));

endmodule

// File: rtl/uart_frame_parser.sv
// Parses SOF/ADDR/LEN/PAYLOAD/CHK frames from the UART RX FIFO, commits verified payloads
// as register writes and answers each frame with ACK or NAK through the UART TX FIFO.
module uart_frame_parser
    import uart_frame_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4,
    parameter int TIMEOUT = 50000,
    parameter int TO_W    = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       rx_empty,
    input  logic [7:0] r_data,
    output logic       rd_uart,
    input  logic       tx_full,
    output logic       wr_uart,
    output logic [7:0] w_data,
    output logic       cmd_valid,
    input  logic       cmd_ready,
    output logic [7:0] cmd_addr,
    output logic [7:0] cmd_data,
    output logic       frame_ok_tick,
    output logic       frame_err_tick,
    output logic       busy
);

    localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    state_e           state_q, state_d;
    logic [LEN_W-1:0] idx_q, idx_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [7:0]       chk_q, chk_d;
    logic [7:0]       addr_q, addr_d;
    logic [7:0]       resp_q, resp_d;
    logic [7:0]       pbuf_q [MAX_LEN];

    logic             byte_avail;
    logic             pop;
    logic             push;
    logic             buf_we;
    logic             to_clear;
    logic             to_en;
    logic             to_expire;
    logic             in_frame;
    logic [IDX_W-1:0] bidx;
    logic             last_idx;

    assign byte_avail = reset_n && !rx_empty;
    assign bidx       = idx_q[IDX_W-1:0];
    assign last_idx   = (idx_q == len_q - LEN_W'(1));
    assign in_frame   = (state_q == ADDR) || (state_q == LEN) ||
                        (state_q == PAYLOAD) || (state_q == CHK);

    // Only the byte-receiving states age the timer; any popped byte restarts it.
    assign to_clear = pop || !in_frame;
    assign to_en    = in_frame && rx_empty;

    frame_timeout #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_timeout (
        .clk      (clk),
        .reset_n  (reset_n),
        .clear_i  (to_clear),
        .en_i     (to_en),
        .expire_o (to_expire)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            len_q   <= '0;
            chk_q   <= '0;
            addr_q  <= '0;
            resp_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            chk_q   <= chk_d;
            addr_q  <= addr_d;
            resp_q  <= resp_d;
        end
    end

    always_ff @(posedge clk) begin
        if (buf_we) begin
            pbuf_q[bidx] <= r_data;
        end
    end

    // Expiry is checked before a waiting byte so a frame that has already timed out is dropped.
    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        len_d          = len_q;
        chk_d          = chk_q;
        addr_d         = addr_q;
        resp_d         = resp_q;
        pop            = 1'b0;
        push           = 1'b0;
        buf_we         = 1'b0;
        cmd_valid      = 1'b0;
        frame_ok_tick  = 1'b0;
        frame_err_tick = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (byte_avail) begin
                    pop = 1'b1;
                    if (r_data == SOF) begin
                        state_d = ADDR;
                    end
                end
            end
            ADDR: begin
                if (to_expire) begin
                    frame_err_tick = 1'b1;
                    state_d        = IDLE;
                end else if (byte_avail) begin
                    pop     = 1'b1;
                    addr_d  = r_data;
                    chk_d   = r_data;
                    state_d = LEN;
                end
            end
            LEN: begin
                if (to_expire) begin
                    frame_err_tick = 1'b1;
                    state_d        = IDLE;
                end else if (byte_avail) begin
                    pop = 1'b1;
                    if ((r_data == 8'h00) || (r_data > 8'(MAX_LEN))) begin
                        resp_d         = NAK;
                        frame_err_tick = 1'b1;
                        state_d        = RESP;
                    end else begin
                        len_d   = r_data[LEN_W-1:0];
                        chk_d   = chk_q ^ r_data;
                        idx_d   = '0;
                        state_d = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                if (to_expire) begin
                    frame_err_tick = 1'b1;
                    state_d        = IDLE;
                end else if (byte_avail) begin
                    pop    = 1'b1;
                    buf_we = 1'b1;
                    chk_d  = chk_q ^ r_data;
                    idx_d  = idx_q + LEN_W'(1);
                    if (last_idx) begin
                        state_d = CHK;
                    end
                end
            end
            CHK: begin
                if (to_expire) begin
                    frame_err_tick = 1'b1;
                    state_d        = IDLE;
                end else if (byte_avail) begin
                    pop = 1'b1;
                    if (r_data == chk_q) begin
                        idx_d   = '0;
                        state_d = COMMIT;
                    end else begin
                        resp_d         = NAK;
                        frame_err_tick = 1'b1;
                        state_d        = RESP;
                    end
                end
            end
            COMMIT: begin
                cmd_valid = 1'b1;
                if (cmd_ready) begin
                    if (last_idx) begin
                        resp_d  = ACK;
                        state_d = RESP;
                    end else begin
                        idx_d = idx_q + LEN_W'(1);
                    end
                end
            end
            RESP: begin
                push = reset_n && !tx_full;
                if (push) begin
                    frame_ok_tick = (resp_q == ACK);
                    state_d       = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign rd_uart  = pop;
    assign wr_uart  = push;
    assign w_data   = (state_q == RESP) ? resp_q : 8'h00;
    assign cmd_addr = cmd_valid ? (addr_q + 8'(idx_q)) : 8'h00;
    assign cmd_data = cmd_valid ? pbuf_q[bidx] : 8'h00;
    assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed bench for uart_frame_parser: scripted RX bytes, logged command writes and TX bytes.
module tb_uart_frame_parser;

    localparam int TOUT = 30;

    logic       clk       = 1'b0;
    logic       reset_n   = 1'b0;
    logic       rx_empty  = 1'b1;
    logic [7:0] r_data    = 8'h00;
    logic       tx_full   = 1'b0;
    logic       cmd_ready = 1'b1;
    logic       rd_uart;
    logic       wr_uart;
    logic [7:0] w_data;
    logic       cmd_valid;
    logic [7:0] cmd_addr;
    logic [7:0] cmd_data;
    logic       frame_ok_tick;
    logic       frame_err_tick;
    logic       busy;

    logic [7:0]  rxQ[$];
    logic [15:0] cmdLog[$];
    logic [7:0]  txLog[$];
    int okTicks  = 0;
    int errTicks = 0;
    int errors   = 0;
    int checks   = 0;

    uart_frame_parser #(
        .MAX_LEN (8),
        .LEN_W   (4),
        .TIMEOUT (TOUT),
        .TO_W    (16)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .rx_empty       (rx_empty),
        .r_data         (r_data),
        .rd_uart        (rd_uart),
        .tx_full        (tx_full),
        .wr_uart        (wr_uart),
        .w_data         (w_data),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_addr       (cmd_addr),
        .cmd_data       (cmd_data),
        .frame_ok_tick  (frame_ok_tick),
        .frame_err_tick (frame_err_tick),
        .busy           (busy)
    );

    always #5 clk = ~clk;

    task automatic refreshRx();
        rx_empty = (rxQ.size() == 0);
        r_data   = (rxQ.size() == 0) ? 8'h00 : rxQ[0];
    endtask

    // RX FIFO model: a pop seen at the edge removes the head shortly after it.
    always @(posedge clk) begin : rxFifo
        logic doPop;
        doPop = rd_uart;
        #1;
        if (doPop && rxQ.size() > 0) rxQ.delete(0);
        refreshRx();
    end

    always @(negedge clk) begin
        if (cmd_valid && cmd_ready) cmdLog.push_back({cmd_addr, cmd_data});
        if (wr_uart) txLog.push_back(w_data);
        if (frame_ok_tick) okTicks++;
        if (frame_err_tick) errTicks++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] cmdAt(input int i);
        if (i < cmdLog.size()) return {16'h0000, cmdLog[i]};
        return 32'hDEAD_BEEF;
    endfunction

    function automatic logic [31:0] txAt(input int i);
        if (i < txLog.size()) return {24'h0, txLog[i]};
        return 32'hDEAD_BEEF;
    endfunction

    task automatic clearLogs();
        cmdLog.delete();
        txLog.delete();
        okTicks  = 0;
        errTicks = 0;
    endtask

    // Bytes are packed most-significant first: the leftmost byte arrives first.
    task automatic applyStimulus(input logic [63:0] bytes, input int n);
        @(posedge clk);
        #2;
        for (int i = 0; i < n; i++) rxQ.push_back(bytes[8*(n-1-i) +: 8]);
        refreshRx();
    endtask

    task automatic waitDone(input string tag, input int limit);
        int quiet = 0;
        int n = 0;
        while (n < limit && quiet < 3) begin
            @(negedge clk);
            n++;
            if (!busy && rxQ.size() == 0) quiet++;
            else quiet = 0;
        end
        checkOutput({tag, "_done"}, 32'(quiet >= 3), 32'd1);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_rd"}, 32'(rd_uart), 32'd0);
        checkOutput({tag, "_wr"}, 32'(wr_uart), 32'd0);
        checkOutput({tag, "_wdata"}, 32'(w_data), 32'd0);
        checkOutput({tag, "_cmd"}, {15'd0, cmd_valid, cmd_addr, cmd_data}, 32'd0);
        checkOutput({tag, "_ticks"}, {30'd0, frame_ok_tick, frame_err_tick}, 32'd0);
    endtask

    // A5 10 02 11 22 21: chk = 10^02^11^22 = 21, writes (10,11) then (11,22), ACK.
    task automatic checkGoodFrame(input string tag);
        clearLogs();
        applyStimulus(64'hA5_10_02_11_22_21, 6);
        waitDone(tag, 40);
        checkOutput({tag, "_ncmd"}, 32'(cmdLog.size()), 32'd2);
        checkOutput({tag, "_cmd0"}, cmdAt(0), 32'h1011);
        checkOutput({tag, "_cmd1"}, cmdAt(1), 32'h1122);
        checkOutput({tag, "_ntx"}, 32'(txLog.size()), 32'd1);
        checkOutput({tag, "_tx"}, txAt(0), 32'h06);
        checkOutput({tag, "_ok"}, 32'(okTicks), 32'd1);
        checkOutput({tag, "_err"}, 32'(errTicks), 32'd0);
    endtask

    task automatic checkNak(input string tag);
        checkOutput({tag, "_ncmd"}, 32'(cmdLog.size()), 32'd0);
        checkOutput({tag, "_ntx"}, 32'(txLog.size()), 32'd1);
        checkOutput({tag, "_tx"}, txAt(0), 32'h15);
        checkOutput({tag, "_err"}, 32'(errTicks), 32'd1);
        checkOutput({tag, "_ok"}, 32'(okTicks), 32'd0);
    endtask

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int n;
        refreshRx();
        repeat (3) @(negedge clk);
        checkResetOutputs("rst0");
        @(posedge clk);
        #2 reset_n = 1'b1;

        checkGoodFrame("good");

        clearLogs();
        applyStimulus(64'hA5_10_02_11_22_20, 6);
        waitDone("badchk", 40);
        checkNak("badchk");

        clearLogs();
        applyStimulus(64'h00_FF_A5_10_00, 5);
        waitDone("len0", 40);
        checkNak("len0");

        clearLogs();
        applyStimulus(64'hA5_10_09, 3);
        waitDone("len9", 40);
        checkNak("len9");

        // Address wrap frame: chk = FF^02^AA^BB = EC.
        clearLogs();
        cmd_ready = 1'b0;
        tx_full   = 1'b1;
        applyStimulus(64'hA5_FF_02_AA_BB_EC, 6);
        n = 0;
        while (!cmd_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        checkOutput("bp_valid", 32'(cmd_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkOutput("bp_hold", {15'd0, cmd_valid, cmd_addr, cmd_data}, {15'd0, 1'b1, 8'hFF, 8'hAA});
        end
        @(posedge clk);
        #2 cmd_ready = 1'b1;
        repeat (10) @(negedge clk);
        checkOutput("bp_txstall_ntx", 32'(txLog.size()), 32'd0);
        checkOutput("bp_txstall_busy", {30'd0, busy, wr_uart}, {30'd0, 1'b1, 1'b0});
        checkOutput("bp_txstall_wdata", 32'(w_data), 32'h06);
        @(posedge clk);
        #2 tx_full = 1'b0;
        waitDone("bp", 40);
        checkOutput("bp_ncmd", 32'(cmdLog.size()), 32'd2);
        checkOutput("bp_cmd0", cmdAt(0), 32'hFFAA);
        checkOutput("bp_cmd1", cmdAt(1), 32'h00BB);
        checkOutput("bp_tx", txAt(0), 32'h06);
        checkOutput("bp_ok", 32'(okTicks), 32'd1);

        clearLogs();
        applyStimulus(64'hA5_10_03_01, 4);
        repeat (TOUT / 2) @(negedge clk);
        checkOutput("to_early_busy", 32'(busy), 32'd1);
        checkOutput("to_early_err", 32'(errTicks), 32'd0);
        waitDone("to", TOUT + 40);
        checkOutput("to_err", 32'(errTicks), 32'd1);
        checkOutput("to_ntx", 32'(txLog.size()), 32'd0);
        checkOutput("to_ncmd", 32'(cmdLog.size()), 32'd0);
        checkGoodFrame("after_to");

        clearLogs();
        applyStimulus(64'hA5_10_02_11, 4);
        repeat (8) @(negedge clk);
        checkOutput("rst_pre_busy", 32'(busy), 32'd1);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        rxQ.push_back(8'h55);
        refreshRx();
        @(negedge clk);
        checkResetOutputs("rst_mid");
        @(posedge clk);
        #2;
        rxQ.delete();
        refreshRx();
        reset_n = 1'b1;
        checkOutput("rst_ncmd", 32'(cmdLog.size()), 32'd0);
        checkOutput("rst_ntx", 32'(txLog.size()), 32'd0);
        checkGoodFrame("after_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
